// File: rtl/term_iq_pkg.sv
// Shared types for the terminate issue queue: operand/entry records and the issue-ready test.
// Tag width is fixed here; queue depth defaults to DEPTH_DEF.
package term_iq_pkg;

    localparam int unsigned TAG_W     = 5;
    localparam int unsigned DEPTH_DEF = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
        logic [7:0]       val;
    } operand_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        operand_t   base_lo;
        operand_t   base_hi;
        operand_t   flag;
        logic [7:0] offset;
        logic [3:0] immediate;
        logic [4:0] rob;
        logic [7:0] arch_dest;
        logic [9:0] phys_dest;
    } entry_t;

    // Unconditional terminates (opcode bit0) do not wait for the flag byte.
    function automatic logic entry_ready(input entry_t e);
        return e.valid & e.base_lo.rdy & e.base_hi.rdy & (e.opcode[0] | e.flag.rdy);
    endfunction

endpackage

// File: rtl/term_iq_operand.sv
// One operand's next value: enqueue-vs-stored mux followed by tag compare and value capture.
// The same path serves stored wakeup and the enqueue-cycle bypass.
module term_iq_operand
    import term_iq_pkg::*;
(
    input  logic             sel_enq,
    input  operand_t         enq_op,
    input  operand_t         cur_op,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [7:0]       cdb_value,
    output operand_t         nxt_op
);

    operand_t src;

    always_comb begin
        src    = sel_enq ? enq_op : cur_op;
        nxt_op = src;
        if (cdb_valid && !src.rdy && (src.tag == cdb_tag)) begin
            nxt_op.rdy = 1'b1;
            nxt_op.val = cdb_value;
        end
    end

endmodule

// File: rtl/terminate_issue_queue_operand.sv
// Thin wrapper kept for the codebase slice layout; the operand logic lives in term_iq_operand.
// Chooses between the enqueue operand and a stored one, then applies result-bus wakeup.
module terminate_issue_queue_operand
    import term_iq_pkg::*;
(
    input  logic             sel_enq,
    input  operand_t         enq_op,
    input  operand_t         cur_op,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [7:0]       cdb_value,
    output operand_t         nxt_op
);

    term_iq_operand u_op (
        .sel_enq   (sel_enq),
        .enq_op    (enq_op),
        .cur_op    (cur_op),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .nxt_op    (nxt_op)
    );

endmodule

// File: rtl/terminate_issue_queue.sv
// Age-ordered collapsing issue queue for terminate instructions, oldest-ready-first issue.
// Define TERM_IQ_ISSUE_REG_EN to add a one-entry registered output stage.
module terminate_issue_queue
    import term_iq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [3:0]       enq_opcode,
    input  logic [TAG_W-1:0] enq_base_lo_tag,
    input  logic [TAG_W-1:0] enq_base_hi_tag,
    input  logic             enq_base_lo_rdy,
    input  logic             enq_base_hi_rdy,
    input  logic [7:0]       enq_base_lo_val,
    input  logic [7:0]       enq_base_hi_val,
    input  logic [TAG_W-1:0] enq_flag_tag,
    input  logic             enq_flag_rdy,
    input  logic [7:0]       enq_flag_val,
    input  logic [7:0]       enq_offset,
    input  logic [3:0]       enq_immediate,
    input  logic [4:0]       enq_rob,
    input  logic [7:0]       enq_arch_dest,
    input  logic [9:0]       enq_phys_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [7:0]       cdb_value,
    output logic [3:0]       opcode,
    output logic [15:0]      reg_base_val,
    output logic [7:0]       flag_vals,
    output logic [7:0]       offset,
    output logic [3:0]       immediate,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [4:0]       ROB_entries,
    output logic [7:0]       arch_dest_regs,
    output logic [9:0]       phys_dest_regs
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    entry_t           slot_q [DEPTH];
    entry_t           src    [DEPTH];
    entry_t           slot_d [DEPTH];
    operand_t         lo_d   [DEPTH];
    operand_t         hi_d   [DEPTH];
    operand_t         fl_d   [DEPTH];
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] enq_here;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             any_rdy;
    logic             remove;
    logic             enq_fire;
    entry_t           enq_entry;
    entry_t           sel_entry;
    entry_t           out_entry;

    assign enq_ready = (count_q < CNT_W'(DEPTH));
    assign enq_fire  = enq_valid & enq_ready;

    always_comb begin
        enq_entry = '{
            valid:     1'b1,
            opcode:    enq_opcode,
            base_lo:   '{tag: enq_base_lo_tag, rdy: enq_base_lo_rdy, val: enq_base_lo_val},
            base_hi:   '{tag: enq_base_hi_tag, rdy: enq_base_hi_rdy, val: enq_base_hi_val},
            flag:      '{tag: enq_flag_tag, rdy: enq_flag_rdy, val: enq_flag_val},
            offset:    enq_offset,
            immediate: enq_immediate,
            rob:       enq_rob,
            arch_dest: enq_arch_dest,
            phys_dest: enq_phys_dest
        };
    end

    // Descending scan so the lowest-index (oldest) ready slot wins.
    always_comb begin
        sel_idx = '0;
        any_rdy = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            rdy_vec[i] = entry_ready(slot_q[i]);
            if (rdy_vec[i]) begin
                sel_idx = IDX_W'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign sel_entry = slot_q[sel_idx];

`ifdef TERM_IQ_ISSUE_REG_EN
    entry_t stage_q;
    entry_t stage_d;
    logic   fire;
    logic   load;

    assign fire   = stage_q.valid & instr_ready;
    assign load   = any_rdy & (~stage_q.valid | instr_ready);
    assign remove = load;

    always_comb begin
        stage_d = stage_q;
        if (load) begin
            stage_d = sel_entry;
        end else if (fire) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_entry = stage_q;
`else
    assign remove    = any_rdy & instr_ready;
    assign out_entry = any_rdy ? sel_entry : '0;
`endif

    // Slots at or above the removed index take their upper neighbour; the enqueue lands at the
    // first free slot after that collapse.
    always_comb begin
        wr_idx = count_q - CNT_W'(remove);
        for (int i = 0; i < int'(DEPTH); i++) begin
            src[i] = slot_q[i];
            if (remove && (i >= int'(sel_idx))) src[i] = '0;
            enq_here[i] = enq_fire && (wr_idx == CNT_W'(i));
        end
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (remove && (i >= int'(sel_idx))) src[i] = slot_q[i+1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        term_iq_operand u_lo (
            .sel_enq   (enq_here[g]),
            .enq_op    (enq_entry.base_lo),
            .cur_op    (src[g].base_lo),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .nxt_op    (lo_d[g])
        );
        term_iq_operand u_hi (
            .sel_enq   (enq_here[g]),
            .enq_op    (enq_entry.base_hi),
            .cur_op    (src[g].base_hi),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .nxt_op    (hi_d[g])
        );
        term_iq_operand u_flag (
            .sel_enq   (enq_here[g]),
            .enq_op    (enq_entry.flag),
            .cur_op    (src[g].flag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .nxt_op    (fl_d[g])
        );
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_d[i]         = enq_here[i] ? enq_entry : src[i];
            slot_d[i].base_lo = lo_d[i];
            slot_d[i].base_hi = hi_d[i];
            slot_d[i].flag    = fl_d[i];
        end
    end

    assign count_d = count_q + CNT_W'(enq_fire) - CNT_W'(remove);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_d[i];
        end
    end

    assign instr_valid    = out_entry.valid;
    assign opcode         = out_entry.opcode;
    assign reg_base_val   = {out_entry.base_hi.val, out_entry.base_lo.val};
    assign flag_vals      = out_entry.flag.val;
    assign offset         = out_entry.offset;
    assign immediate      = out_entry.immediate;
    assign ROB_entries    = out_entry.rob;
    assign arch_dest_regs = out_entry.arch_dest;
    assign phys_dest_regs = out_entry.phys_dest;

    // Tags and ready bits stop at the queue boundary.
    logic unused_out;
    assign unused_out = ^{out_entry.base_lo.tag, out_entry.base_lo.rdy,
                          out_entry.base_hi.tag, out_entry.base_hi.rdy,
                          out_entry.flag.tag, out_entry.flag.rdy};

endmodule

// File: tb/tb_terminate_issue_queue.sv
// Self-checking bench for terminate_issue_queue (default build, combinational issue).
// Issued instructions are checked against a scoreboard of expected records in issue order.
module tb_terminate_issue_queue;
    import term_iq_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, flush, enq_valid, enq_ready;
    logic [3:0]       enq_opcode;
    logic [TAG_W-1:0] enq_base_lo_tag, enq_base_hi_tag, enq_flag_tag, cdb_tag;
    logic             enq_base_lo_rdy, enq_base_hi_rdy, enq_flag_rdy, cdb_valid;
    logic [7:0]       enq_base_lo_val, enq_base_hi_val, enq_flag_val, enq_offset, cdb_value;
    logic [3:0]       enq_immediate, opcode, immediate;
    logic [4:0]       enq_rob, ROB_entries;
    logic [7:0]       enq_arch_dest, flag_vals, offset, arch_dest_regs;
    logic [9:0]       enq_phys_dest, phys_dest_regs;
    logic [15:0]      reg_base_val;
    logic             instr_valid, instr_ready;

    int          checks = 0;
    int          errors = 0;
    logic [62:0] exp_q [$];
    logic        last_acc;

    always #5 clk = ~clk;

    terminate_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_opcode(enq_opcode),
        .enq_base_lo_tag(enq_base_lo_tag), .enq_base_hi_tag(enq_base_hi_tag),
        .enq_base_lo_rdy(enq_base_lo_rdy), .enq_base_hi_rdy(enq_base_hi_rdy),
        .enq_base_lo_val(enq_base_lo_val), .enq_base_hi_val(enq_base_hi_val),
        .enq_flag_tag(enq_flag_tag), .enq_flag_rdy(enq_flag_rdy), .enq_flag_val(enq_flag_val),
        .enq_offset(enq_offset), .enq_immediate(enq_immediate), .enq_rob(enq_rob),
        .enq_arch_dest(enq_arch_dest), .enq_phys_dest(enq_phys_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .opcode(opcode), .reg_base_val(reg_base_val), .flag_vals(flag_vals),
        .offset(offset), .immediate(immediate),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ROB_entries(ROB_entries), .arch_dest_regs(arch_dest_regs),
        .phys_dest_regs(phys_dest_regs)
    );

    function automatic logic [7:0] off_of(input logic [4:0] rob);
        return {3'b010, rob};
    endfunction
    function automatic logic [3:0] imm_of(input logic [4:0] rob);
        return rob[3:0] + 4'd2;
    endfunction
    function automatic logic [7:0] arch_of(input logic [4:0] rob);
        return {rob, 3'b110};
    endfunction
    function automatic logic [9:0] phys_of(input logic [4:0] rob);
        return {rob, 5'b10011};
    endfunction
    function automatic logic [7:0] lo_of(input logic [4:0] rob);
        return {rob, 3'b001};
    endfunction
    function automatic logic [7:0] hi_of(input logic [4:0] rob);
        return {3'b101, rob};
    endfunction
    function automatic logic [7:0] fl_of(input logic [4:0] rob);
        return ~{3'b000, rob};
    endfunction

    function automatic logic [62:0] pack_exp(input logic [3:0] op, input logic [7:0] hi,
                                             input logic [7:0] lo, input logic [7:0] fl,
                                             input logic [4:0] rob);
        return {op, hi, lo, fl, off_of(rob), imm_of(rob), rob, arch_of(rob), phys_of(rob)};
    endfunction

    function automatic logic [62:0] exp_ready(input logic [4:0] rob);
        return pack_exp(4'h1, hi_of(rob), lo_of(rob), fl_of(rob), rob);
    endfunction

    task automatic set_enq(input logic [3:0] op,
                           input logic [TAG_W-1:0] lt, input logic lr, input logic [7:0] lv,
                           input logic [TAG_W-1:0] ht, input logic hr, input logic [7:0] hv,
                           input logic [TAG_W-1:0] ft, input logic fr, input logic [7:0] fv,
                           input logic [4:0] rob);
        enq_valid       = 1'b1;
        enq_opcode      = op;
        enq_base_lo_tag = lt; enq_base_lo_rdy = lr; enq_base_lo_val = lv;
        enq_base_hi_tag = ht; enq_base_hi_rdy = hr; enq_base_hi_val = hv;
        enq_flag_tag    = ft; enq_flag_rdy    = fr; enq_flag_val    = fv;
        enq_offset      = off_of(rob);
        enq_immediate   = imm_of(rob);
        enq_rob         = rob;
        enq_arch_dest   = arch_of(rob);
        enq_phys_dest   = phys_of(rob);
    endtask

    task automatic set_ready(input logic [4:0] rob);
        set_enq(4'h1, 5'd31, 1'b1, lo_of(rob), 5'd30, 1'b1, hi_of(rob),
                5'd29, 1'b1, fl_of(rob), rob);
    endtask

    // One clock: sample at the falling edge, score any fire, then step past the rising edge.
    task automatic cycle();
        logic [62:0] obs;
        logic [62:0] e;
        @(negedge clk);
        last_acc = enq_valid & enq_ready;
        if (instr_valid && instr_ready) begin
            obs = {opcode, reg_base_val, flag_vals, offset, immediate, ROB_entries,
                   arch_dest_regs, phys_dest_regs};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got %h, required no issue", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL issue_data: got %h, required %h", obs, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        instr_ready = 1'b1;
        for (int n = 0; n < max_cycles && (exp_q.size() != 0 || instr_valid); n++) cycle();
        instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got %0d pending valid=%b, required 0 pending valid=0",
                     exp_q.size(), instr_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++; $display("FAIL reset_enq_ready: got %b, required 1", enq_ready);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid);
        end
        checks++;
        if (reg_base_val !== 16'h0) begin
            errors++; $display("FAIL reset_base: got %h, required 0000", reg_base_val);
        end
        checks++;
        if ({ROB_entries, phys_dest_regs, opcode} !== '0) begin
            errors++;
            $display("FAIL reset_meta: got %h, required 0", {ROB_entries, phys_dest_regs, opcode});
        end
    endtask

    task automatic test_basic();
        instr_ready = 1'b0;
        set_enq(4'h1, 5'd1, 1'b1, 8'h34, 5'd2, 1'b1, 8'h12, 5'd3, 1'b1, 8'h00, 5'd3);
        exp_q.push_back(pack_exp(4'h1, 8'h12, 8'h34, 8'h00, 5'd3));
        cycle();
        enq_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b, required 1", instr_valid);
        end
        checks++;
        if (reg_base_val !== 16'h1234) begin
            errors++; $display("FAIL basic_base: got %h, required 1234", reg_base_val);
        end
        checks++;
        if (ROB_entries !== 5'd3 || immediate !== 4'd5) begin
            errors++;
            $display("FAIL basic_rob_imm: got %0d/%0d, required 3/5", ROB_entries, immediate);
        end
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_empty: got valid=%b pending=%0d, required 0/0",
                     instr_valid, exp_q.size());
        end
    endtask

    task automatic test_wakeup();
        instr_ready = 1'b1;
        set_enq(4'h0, 5'd1, 1'b1, 8'h11, 5'd2, 1'b1, 8'h22, 5'd7, 1'b0, 8'h00, 5'd5);
        cycle();
        enq_valid = 1'b0;
        cycle();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL wake_blocked: got %b, required 0", instr_valid);
        end
        instr_ready = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 8'h81;
        exp_q.push_back(pack_exp(4'h0, 8'h22, 8'h11, 8'h81, 5'd5));
        cycle();
        cdb_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || flag_vals !== 8'h81) begin
            errors++;
            $display("FAIL wake_flag: got valid=%b flag=%h, required 1/81", instr_valid, flag_vals);
        end
        drain(4);
    endtask

    task automatic test_bypass_order();
        instr_ready = 1'b0;
        set_enq(4'h1, 5'd4, 1'b0, 8'h00, 5'd10, 1'b1, 8'h66, 5'd11, 1'b1, 8'h06, 5'd6);
        cycle();
        set_ready(5'd7);
        exp_q.push_back(exp_ready(5'd7));
        cycle();
        enq_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || ROB_entries !== 5'd7) begin
            errors++;
            $display("FAIL order_young_first: got valid=%b rob=%0d, required 1/7",
                     instr_valid, ROB_entries);
        end
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL order_old_blocked: got %b, required 0", instr_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_value = 8'h4C;
        exp_q.push_back(pack_exp(4'h1, 8'h66, 8'h4C, 8'h06, 5'd6));
        cycle();
        cdb_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || ROB_entries !== 5'd6) begin
            errors++;
            $display("FAIL order_old_wake: got valid=%b rob=%0d, required 1/6",
                     instr_valid, ROB_entries);
        end
        drain(6);
    endtask

    task automatic test_multi_wakeup();
        instr_ready = 1'b0;
        set_enq(4'h1, 5'd12, 1'b0, 8'h00, 5'd1, 1'b1, 8'h88, 5'd2, 1'b1, 8'h08, 5'd8);
        cycle();
        set_enq(4'h0, 5'd3, 1'b1, 8'h99, 5'd12, 1'b0, 8'h00, 5'd12, 1'b0, 8'h00, 5'd9);
        cycle();
        enq_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL multi_blocked: got %b, required 0", instr_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_value = 8'h3C;
        exp_q.push_back(pack_exp(4'h1, 8'h88, 8'h3C, 8'h08, 5'd8));
        exp_q.push_back(pack_exp(4'h0, 8'h3C, 8'h99, 8'h3C, 5'd9));
        cycle();
        cdb_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || ROB_entries !== 5'd8) begin
            errors++;
            $display("FAIL multi_wake: got valid=%b rob=%0d, required 1/8",
                     instr_valid, ROB_entries);
        end
        drain(6);
    endtask

    task automatic test_full();
        instr_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_ready(5'(16 + i));
            exp_q.push_back(exp_ready(5'(16 + i)));
            cycle();
        end
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++; $display("FAIL full_enq_ready: got %b, required 0", enq_ready);
        end
        set_ready(5'd24);
        cycle();
        checks++;
        if (last_acc !== 1'b0) begin
            errors++; $display("FAIL full_reject: got accept=%b, required 0", last_acc);
        end
        enq_valid = 1'b0;
        instr_ready = 1'b1;
        cycle();
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++; $display("FAIL full_after_fire: got %b, required 1", enq_ready);
        end
        set_ready(5'd25);
        exp_q.push_back(exp_ready(5'd25));
        cycle();
        checks++;
        if (last_acc !== 1'b1 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fire_enq: got accept=%b enq_ready=%b, required 1/1",
                     last_acc, enq_ready);
        end
        instr_ready = 1'b0;
        set_ready(5'd26);
        exp_q.push_back(exp_ready(5'd26));
        cycle();
        enq_valid = 1'b0;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++; $display("FAIL full_refill: got %b, required 0", enq_ready);
        end
        drain(12);
    endtask

    task automatic test_enq_bypass();
        instr_ready = 1'b0;
        set_enq(4'h1, 5'd9, 1'b0, 8'h00, 5'd2, 1'b1, 8'hAB, 5'd3, 1'b1, 8'hCD, 5'd10);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 8'h55;
        exp_q.push_back(pack_exp(4'h1, 8'hAB, 8'h55, 8'hCD, 5'd10));
        cycle();
        enq_valid = 1'b0;
        cdb_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || reg_base_val !== 16'hAB55) begin
            errors++;
            $display("FAIL bypass_hit: got valid=%b base=%h, required 1/ab55",
                     instr_valid, reg_base_val);
        end
        drain(4);
        set_enq(4'h1, 5'd9, 1'b0, 8'h00, 5'd2, 1'b1, 8'hAB, 5'd3, 1'b1, 8'hCD, 5'd11);
        cdb_valid = 1'b1; cdb_tag = 5'd8; cdb_value = 8'h66;
        cycle();
        enq_valid = 1'b0;
        cdb_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_miss: got %b, required 0", instr_valid);
        end
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 8'h77;
        exp_q.push_back(pack_exp(4'h1, 8'hAB, 8'h77, 8'hCD, 5'd11));
        cycle();
        cdb_valid = 1'b0;
        drain(4);
    endtask

    task automatic test_flush();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ready(5'(28 + i));
            cycle();
        end
        // The handshake in the flush cycle still completes downstream.
        set_ready(5'd31);
        exp_q.push_back(exp_ready(5'd28));
        flush = 1'b1;
        instr_ready = 1'b1;
        cycle();
        flush = 1'b0;
        enq_valid = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got valid=%b enq_ready=%b, required 0/1",
                     instr_valid, enq_ready);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (enq_ready !== 1'b1) begin
                errors++; $display("FAIL flush_count: got enq_ready=%b at %0d, required 1", enq_ready, i);
            end
            set_ready(5'(1 + i));
            exp_q.push_back(exp_ready(5'(1 + i)));
            cycle();
        end
        enq_valid = 1'b0;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++; $display("FAIL flush_refill: got %b, required 0", enq_ready);
        end
        drain(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; instr_ready = 1'b0; cdb_valid = 1'b0;
        cdb_tag = '0; cdb_value = '0; last_acc = 1'b0;
        set_enq(4'h0, 5'd0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);
        enq_valid = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass_order();
        test_multi_wakeup();
        test_full();
        test_enq_bypass();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
